// File: rtl/zynet_pkg.sv
// Shared register offsets, response codes and FSM state types for the zyNet AXI4-Lite register block.
package zynet_pkg;

    localparam logic [2:0] REG_WEIGHT  = 3'd0;
    localparam logic [2:0] REG_BIAS    = 3'd1;
    localparam logic [2:0] REG_RESULT  = 3'd2;
    localparam logic [2:0] REG_LAYER   = 3'd3;
    localparam logic [2:0] REG_NEURON  = 3'd4;
    localparam logic [2:0] REG_NOUT    = 3'd5;
    localparam logic [2:0] REG_STATUS  = 3'd6;
    localparam logic [2:0] REG_SOFTRST = 3'd7;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_GOT_AW,
        WR_GOT_W,
        WR_RESP
    } wr_state_e;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_e;

    // Byte-lane merge of a 32-bit write into an existing register value.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] res;
        res = old_val;
        for (int unsigned i = 0; i < 4; i++) begin
            if (wstrb[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/zynet_axil_slave_regs_if.sv
// AXI4-Lite bus bundle between the host (master) and the zyNet register block (slave).
interface zynet_axil_slave_regs_if #(
    parameter int unsigned ADDR_W = 5
);
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/zynet_out_fifo.sv
// Synchronous neuron-output FIFO; async reset plus a synchronous flush. A pop frees space for a same-cycle push.
module zynet_out_fifo #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];
    assign do_pop    = pop && !empty && !flush;
    assign do_push   = push && (!full || do_pop) && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/zynet_axil_slave_regs.sv
// zyNet AXI4-Lite control/status register block: load pulses, layer/neuron/soft-reset settings,
// result with interrupt, and a buffered neuron-output read port.
module zynet_axil_slave_regs
    import zynet_pkg::*;
#(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_areset,
    zynet_axil_slave_regs_if.slave  s_axi,
    output logic                    weight_valid,
    output logic [DATA_W-1:0]       weight_data,
    output logic                    bias_valid,
    output logic [DATA_W-1:0]       bias_data,
    output logic [31:0]             layer_num,
    output logic [31:0]             neuron_num,
    output logic                    soft_reset,
    input  logic                    result_valid,
    input  logic [31:0]             result_data,
    input  logic                    nout_valid,
    input  logic [DATA_W-1:0]       nout_data,
    output logic                    intr
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    wr_state_e         wr_state_q, wr_state_d;
    rd_state_e         rd_state_q, rd_state_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              weight_valid_q, weight_valid_d;
    logic [DATA_W-1:0] weight_data_q, weight_data_d;
    logic              bias_valid_q, bias_valid_d;
    logic [DATA_W-1:0] bias_data_q, bias_data_d;
    logic [31:0]       layer_q, layer_d;
    logic [31:0]       neuron_q, neuron_d;
    logic              soft_reset_q, soft_reset_d;
    logic [31:0]       result_q, result_d;
    logic              intr_q, intr_d;
    logic              overflow_q, overflow_d;

    logic              aw_hs, w_hs, ar_hs, wr_exec;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_strb;
    logic [31:0]       rd_val;
    logic [1:0]        rd_resp;
    logic              rd_pop, clr_intr, clr_overflow;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full, fifo_empty, fifo_drop;
    logic [CNT_W-1:0]  fifo_count;
    logic              unused_prot;

    assign unused_prot = ^{s_axi.awprot, s_axi.arprot};

    function automatic logic addr_in_map(input logic [ADDR_W-1:0] a);
        return (a[1:0] == 2'b00) && ((a >> 5) == '0);
    endfunction

    assign aw_hs = s_axi.awvalid && s_axi.awready;
    assign w_hs  = s_axi.wvalid && s_axi.wready;
    assign ar_hs = s_axi.arvalid && s_axi.arready;

    // ---------------- write FSM ----------------
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) wr_state_q <= WR_IDLE;
        else              wr_state_q <= wr_state_d;
    end

    always_comb begin
        wr_state_d = wr_state_q;
        unique case (wr_state_q)
            WR_IDLE: begin
                if (aw_hs && w_hs) wr_state_d = WR_RESP;
                else if (aw_hs)    wr_state_d = WR_GOT_AW;
                else if (w_hs)     wr_state_d = WR_GOT_W;
            end
            WR_GOT_AW: if (w_hs)          wr_state_d = WR_RESP;
            WR_GOT_W:  if (aw_hs)         wr_state_d = WR_RESP;
            WR_RESP:   if (s_axi.bready)  wr_state_d = WR_IDLE;
            default:                      wr_state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        s_axi.awready = (wr_state_q == WR_IDLE) || (wr_state_q == WR_GOT_W);
        s_axi.wready  = (wr_state_q == WR_IDLE) || (wr_state_q == WR_GOT_AW);
        s_axi.bvalid  = (wr_state_q == WR_RESP);
        s_axi.bresp   = bresp_q;
    end

    // The register action fires on the edge that completes the second handshake, so the
    // half that arrives this cycle is taken straight from the bus rather than the holding regs.
    assign wr_exec = (wr_state_q != WR_RESP) && (wr_state_d == WR_RESP);
    assign wr_addr = aw_hs ? s_axi.awaddr : awaddr_q;
    assign wr_data = w_hs  ? s_axi.wdata  : wdata_q;
    assign wr_strb = w_hs  ? s_axi.wstrb  : wstrb_q;
    assign awaddr_d = wr_addr;
    assign wdata_d  = wr_data;
    assign wstrb_d  = wr_strb;

    always_comb begin
        bresp_d        = bresp_q;
        weight_valid_d = 1'b0;
        bias_valid_d   = 1'b0;
        weight_data_d  = weight_data_q;
        bias_data_d    = bias_data_q;
        layer_d        = layer_q;
        neuron_d       = neuron_q;
        soft_reset_d   = soft_reset_q;
        if (wr_exec) begin
            bresp_d = RESP_SLVERR;
            if (addr_in_map(wr_addr)) begin
                bresp_d = RESP_OKAY;
                case (wr_addr[4:2])
                    REG_WEIGHT: begin
                        weight_valid_d = 1'b1;
                        weight_data_d  = wr_data[DATA_W-1:0];
                    end
                    REG_BIAS: begin
                        bias_valid_d = 1'b1;
                        bias_data_d  = wr_data[DATA_W-1:0];
                    end
                    REG_LAYER:   layer_d  = apply_wstrb(layer_q, wr_data, wr_strb);
                    REG_NEURON:  neuron_d = apply_wstrb(neuron_q, wr_data, wr_strb);
                    REG_SOFTRST: if (wr_strb[0]) soft_reset_d = wr_data[0];
                    default:     bresp_d = RESP_SLVERR;
                endcase
            end
        end
    end

    // ---------------- read FSM ----------------
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) rd_state_q <= RD_IDLE;
        else              rd_state_q <= rd_state_d;
    end

    always_comb begin
        rd_state_d = rd_state_q;
        unique case (rd_state_q)
            RD_IDLE: if (ar_hs)        rd_state_d = RD_RESP;
            RD_RESP: if (s_axi.rready) rd_state_d = RD_IDLE;
            default:                   rd_state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        s_axi.arready = (rd_state_q == RD_IDLE);
        s_axi.rvalid  = (rd_state_q == RD_RESP);
        s_axi.rdata   = rdata_q;
        s_axi.rresp   = rresp_q;
    end

    // Read side effects (pop, intr/overflow clear) commit at the AR handshake with the data latch.
    always_comb begin
        rd_val       = '0;
        rd_resp      = RESP_OKAY;
        rd_pop       = 1'b0;
        clr_intr     = 1'b0;
        clr_overflow = 1'b0;
        if (!addr_in_map(s_axi.araddr)) begin
            rd_resp = RESP_SLVERR;
        end else begin
            case (s_axi.araddr[4:2])
                REG_RESULT: begin
                    rd_val   = result_q;
                    clr_intr = ar_hs;
                end
                REG_LAYER:   rd_val = layer_q;
                REG_NEURON:  rd_val = neuron_q;
                REG_SOFTRST: rd_val = {31'b0, soft_reset_q};
                REG_NOUT: begin
                    rd_val = fifo_empty ? '0 : 32'(fifo_head);
                    rd_pop = ar_hs && !fifo_empty;
                end
                REG_STATUS: begin
                    rd_val       = {16'b0, 8'(fifo_count), 6'b0, overflow_q, intr_q};
                    clr_overflow = ar_hs;
                end
                default: rd_resp = RESP_SLVERR;
            endcase
        end
        rdata_d = ar_hs ? rd_val  : rdata_q;
        rresp_d = ar_hs ? rd_resp : rresp_q;
    end

    // ---------------- result / interrupt / overflow ----------------
    assign fifo_drop = nout_valid && fifo_full && !rd_pop && !soft_reset_q;

    always_comb begin
        result_d   = result_q;
        intr_d     = intr_q;
        overflow_d = overflow_q;
        if (soft_reset_q) begin
            result_d   = '0;
            intr_d     = 1'b0;
            overflow_d = 1'b0;
        end else begin
            if (result_valid) result_d = result_data;
            if (result_valid)  intr_d = 1'b1;
            else if (clr_intr) intr_d = 1'b0;
            if (fifo_drop)         overflow_d = 1'b1;
            else if (clr_overflow) overflow_d = 1'b0;
        end
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            awaddr_q       <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            bresp_q        <= RESP_OKAY;
            rdata_q        <= '0;
            rresp_q        <= RESP_OKAY;
            weight_valid_q <= 1'b0;
            weight_data_q  <= '0;
            bias_valid_q   <= 1'b0;
            bias_data_q    <= '0;
            layer_q        <= '0;
            neuron_q       <= '0;
            soft_reset_q   <= 1'b1;
            result_q       <= '0;
            intr_q         <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            awaddr_q       <= awaddr_d;
            wdata_q        <= wdata_d;
            wstrb_q        <= wstrb_d;
            bresp_q        <= bresp_d;
            rdata_q        <= rdata_d;
            rresp_q        <= rresp_d;
            weight_valid_q <= weight_valid_d;
            weight_data_q  <= weight_data_d;
            bias_valid_q   <= bias_valid_d;
            bias_data_q    <= bias_data_d;
            layer_q        <= layer_d;
            neuron_q       <= neuron_d;
            soft_reset_q   <= soft_reset_d;
            result_q       <= result_d;
            intr_q         <= intr_d;
            overflow_q     <= overflow_d;
        end
    end

    zynet_out_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_out_fifo (
        .clk       (s_axi_aclk),
        .rst       (s_axi_areset),
        .flush     (soft_reset_q),
        .push      (nout_valid),
        .push_data (nout_data),
        .pop       (rd_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign weight_valid = weight_valid_q;
    assign weight_data  = weight_data_q;
    assign bias_valid   = bias_valid_q;
    assign bias_data    = bias_data_q;
    assign layer_num    = layer_q;
    assign neuron_num   = neuron_q;
    assign soft_reset   = soft_reset_q;
    assign intr         = intr_q;

endmodule

// File: tb/tb_zynet_axil_slave_regs.sv
// Scoreboard bench for zynet_axil_slave_regs: expected B/R responses queued at issue, checked on arrival.
module tb_zynet_axil_slave_regs;
    import zynet_pkg::*;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 16;
    localparam int          LIMIT  = 40;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              weight_valid, bias_valid, soft_reset, intr;
    logic [DATA_W-1:0] weight_data, bias_data;
    logic [31:0]       layer_num, neuron_num;
    logic              result_valid = 1'b0;
    logic [31:0]       result_data  = '0;
    logic              nout_valid   = 1'b0;
    logic [DATA_W-1:0] nout_data    = '0;

    int   n_total = 0;
    int   n_bad   = 0;
    int   weight_pulses = 0;
    int   bias_pulses   = 0;
    exp_t rd_q[$];
    exp_t wr_q[$];

    zynet_axil_slave_regs_if #(.ADDR_W(ADDR_W)) s_axi ();

    zynet_axil_slave_regs #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .s_axi_aclk   (clk),
        .s_axi_areset (rst),
        .s_axi        (s_axi),
        .weight_valid (weight_valid),
        .weight_data  (weight_data),
        .bias_valid   (bias_valid),
        .bias_data    (bias_data),
        .layer_num    (layer_num),
        .neuron_num   (neuron_num),
        .soft_reset   (soft_reset),
        .result_valid (result_valid),
        .result_data  (result_data),
        .nout_valid   (nout_valid),
        .nout_data    (nout_data),
        .intr         (intr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (weight_valid) weight_pulses++;
        if (bias_valid)   bias_pulses++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive AW and W (W optionally leading by w_lead cycles); both handshakes complete before return.
    task automatic issue_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input int w_lead, input string tag);
        logic aw_pend, w_pend, aw_go, w_go;
        int   n;
        s_axi.awaddr = addr;
        s_axi.wdata  = data;
        s_axi.wstrb  = strb;
        s_axi.wvalid = 1'b1;
        w_pend  = 1'b1;
        aw_pend = (w_lead == 0);
        s_axi.awvalid = aw_pend;
        n = 0;
        while ((aw_pend || w_pend) && n < LIMIT) begin
            aw_go = aw_pend && s_axi.awready;
            w_go  = w_pend && s_axi.wready;
            step();
            if (aw_go) begin aw_pend = 1'b0; s_axi.awvalid = 1'b0; end
            if (w_go)  begin w_pend = 1'b0;  s_axi.wvalid  = 1'b0; end
            if (!w_pend && !aw_pend && s_axi.awvalid == 1'b0 && w_lead > 0 && n == 0) begin
                repeat (w_lead) step();
                aw_pend = 1'b1;
                s_axi.awvalid = 1'b1;
            end
            n++;
        end
        if (n >= LIMIT) check_eq({tag, "_addr_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic axi_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int w_lead, input int b_hold,
                             input logic [1:0] exp_resp, input string tag);
        exp_t e;
        int   n;
        wr_q.push_back('{tag, 32'd0, exp_resp});
        issue_write(addr, data, strb, w_lead, tag);
        n = 0;
        while (!s_axi.bvalid && n < LIMIT) begin step(); n++; end
        if (n >= LIMIT) check_eq({tag, "_b_timeout"}, 32'd0, 32'd1);
        repeat (b_hold) begin
            step();
            check_eq({tag, "_bvalid_hold"}, 32'(s_axi.bvalid), 32'd1);
        end
        e = wr_q.pop_front();
        check_eq({e.tag, "_bresp"}, 32'(s_axi.bresp), 32'(e.resp));
        s_axi.bready = 1'b1;
        step();
        s_axi.bready = 1'b0;
        check_eq({tag, "_bvalid_drop"}, 32'(s_axi.bvalid), 32'd0);
    endtask

    task automatic axi_read(input logic [ADDR_W-1:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input int r_hold, input string tag);
        exp_t e;
        int   n;
        rd_q.push_back('{tag, exp_data, exp_resp});
        s_axi.araddr  = addr;
        s_axi.arvalid = 1'b1;
        n = 0;
        while (!s_axi.arready && n < LIMIT) begin step(); n++; end
        step();
        s_axi.arvalid = 1'b0;
        while (!s_axi.rvalid && n < LIMIT) begin step(); n++; end
        if (n >= LIMIT) check_eq({tag, "_r_timeout"}, 32'd0, 32'd1);
        repeat (r_hold) begin
            step();
            check_eq({tag, "_rvalid_hold"}, 32'(s_axi.rvalid), 32'd1);
            check_eq({tag, "_rdata_hold"}, s_axi.rdata, exp_data);
            check_eq({tag, "_arready_low"}, 32'(s_axi.arready), 32'd0);
        end
        e = rd_q.pop_front();
        check_eq({e.tag, "_rdata"}, s_axi.rdata, e.data);
        check_eq({e.tag, "_rresp"}, 32'(s_axi.rresp), 32'(e.resp));
        s_axi.rready = 1'b1;
        step();
        s_axi.rready = 1'b0;
        check_eq({tag, "_rvalid_drop"}, 32'(s_axi.rvalid), 32'd0);
    endtask

    initial begin
        int n;
        s_axi.awaddr = '0; s_axi.awprot = '0; s_axi.awvalid = 1'b0;
        s_axi.wdata  = '0; s_axi.wstrb  = '0; s_axi.wvalid  = 1'b0;
        s_axi.bready = 1'b0;
        s_axi.araddr = '0; s_axi.arprot = '0; s_axi.arvalid = 1'b0;
        s_axi.rready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // 1: reset state, then leave soft reset
        check_eq("rst_awready", 32'(s_axi.awready), 32'd1);
        check_eq("rst_wready", 32'(s_axi.wready), 32'd1);
        check_eq("rst_arready", 32'(s_axi.arready), 32'd1);
        check_eq("rst_bvalid", 32'(s_axi.bvalid), 32'd0);
        check_eq("rst_rvalid", 32'(s_axi.rvalid), 32'd0);
        check_eq("rst_soft_reset", 32'(soft_reset), 32'd1);
        check_eq("rst_intr", 32'(intr), 32'd0);
        check_eq("rst_layer", layer_num, 32'd0);
        axi_write(6'h1C, 32'h0, 4'hF, 0, 0, RESP_OKAY, "wr_softrst");
        check_eq("soft_reset_clr", 32'(soft_reset), 32'd0);

        // 2: W leads AW, bvalid held while bready low
        axi_write(6'h00, 32'h0001_2345, 4'hF, 3, 3, RESP_OKAY, "wr_weight");
        check_eq("weight_pulses", weight_pulses, 32'd1);
        check_eq("weight_data", 32'(weight_data), 32'h2345);

        // 3: strobed RW, error writes leave state unchanged
        axi_write(6'h0C, 32'hAABB_CC03, 4'b0001, 0, 0, RESP_OKAY, "wr_layer");
        axi_write(6'h10, 32'h0000_001D, 4'hF, 0, 0, RESP_OKAY, "wr_neuron");
        axi_read(6'h0C, 32'h0000_0003, RESP_OKAY, 0, "rd_layer");
        axi_read(6'h10, 32'h0000_001D, RESP_OKAY, 0, "rd_neuron");
        axi_write(6'h24, 32'hFFFF_FFFF, 4'hF, 0, 0, RESP_SLVERR, "wr_unmapped");
        axi_write(6'h0D, 32'hFFFF_FFFF, 4'hF, 0, 0, RESP_SLVERR, "wr_misaligned");
        axi_write(6'h14, 32'hFFFF_FFFF, 4'hF, 0, 0, RESP_SLVERR, "wr_ro");
        check_eq("bias_pulses", bias_pulses, 32'd0);
        axi_read(6'h0C, 32'h0000_0003, RESP_OKAY, 0, "rd_layer_kept");
        axi_read(6'h24, 32'h0, RESP_SLVERR, 0, "rd_unmapped");
        axi_read(6'h00, 32'h0, RESP_SLVERR, 0, "rd_wo");
        check_eq("layer_num", layer_num, 32'h3);
        check_eq("neuron_num", neuron_num, 32'h1D);

        // 4: result and interrupt
        result_data  = 32'd7;
        result_valid = 1'b1;
        step();
        result_valid = 1'b0;
        check_eq("intr_set", 32'(intr), 32'd1);
        axi_read(6'h08, 32'd7, RESP_OKAY, 0, "rd_result");
        check_eq("intr_clr", 32'(intr), 32'd0);

        // 5: FIFO overflow and drain
        for (int i = 0; i < 17; i++) begin
            nout_valid = 1'b1;
            nout_data  = DATA_W'(i);
            step();
        end
        nout_valid = 1'b0;
        axi_read(6'h18, 32'h0000_1002, RESP_OKAY, 0, "rd_status_ovf");
        axi_read(6'h18, 32'h0000_1000, RESP_OKAY, 0, "rd_status_clr");
        for (int i = 0; i < 16; i++) begin
            axi_read(6'h14, 32'(i), RESP_OKAY, 0, $sformatf("rd_nout%0d", i));
        end
        axi_read(6'h14, 32'h0, RESP_OKAY, 0, "rd_nout_empty");
        axi_read(6'h18, 32'h0, RESP_OKAY, 0, "rd_status_empty");

        // 6: R held with rready low, then reset during B phase
        axi_read(6'h10, 32'h0000_001D, RESP_OKAY, 5, "rd_hold");
        issue_write(6'h0C, 32'h0000_00FF, 4'hF, 0, "wr_abort");
        n = 0;
        while (!s_axi.bvalid && n < LIMIT) begin step(); n++; end
        check_eq("abort_bvalid_up", 32'(s_axi.bvalid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("abort_bvalid", 32'(s_axi.bvalid), 32'd0);
        check_eq("abort_awready", 32'(s_axi.awready), 32'd1);
        check_eq("abort_layer", layer_num, 32'd0);
        check_eq("abort_soft_reset", 32'(soft_reset), 32'd1);
        step();
        rst = 1'b0;
        step();
        check_eq("post_rst_bvalid", 32'(s_axi.bvalid), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
